// File: rtl/arb_mux.sv
// N-way arbitrating stream multiplexer with round-robin or fixed-priority grant,
// packet locking and a single registered output stage.
module arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = 2,
  parameter int MODE  = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_last,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  output logic [SELW-1:0]    out_sel,
  input  logic               out_ready
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;
  logic [SELW-1:0]  r_out_sel;
  logic [IW-1:0]    r_ptr;
  logic             r_lock;
  logic [IW-1:0]    r_locked_ch;

  logic             w_can_load;
  logic             w_gnt_vld;
  logic [IW-1:0]    w_gnt_idx;
  logic             w_accept;
  logic [WIDTH-1:0] w_gnt_data;
  logic             w_gnt_last;
  logic [IW-1:0]    w_next_ptr;
  logic [N-1:0]     w_in_ready;
  int               w_rr_idx;

  // Reset gates loading so no beat is offered while the block is being cleared.
  assign w_can_load = !reset && (!r_out_valid || out_ready);
  assign w_accept   = w_can_load && w_gnt_vld;
  assign w_next_ptr = (w_gnt_idx == IW'(N - 1)) ? {IW{1'b0}} : (w_gnt_idx + IW'(1));

  // Grant selection: lock owner, else lowest index (fixed) or first from ptr (round-robin).
  always_comb begin
    w_gnt_idx = r_locked_ch;
    w_gnt_vld = 1'b0;
    w_rr_idx  = 0;
    if (r_lock) begin
      w_gnt_idx = r_locked_ch;
      w_gnt_vld = in_valid[r_locked_ch];
    end else if (MODE == 1) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (in_valid[IW'(i)]) begin
          w_gnt_idx = IW'(i);
          w_gnt_vld = 1'b1;
        end
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        w_rr_idx = int'(r_ptr) + k;
        if (w_rr_idx >= N) begin
          w_rr_idx = w_rr_idx - N;
        end else begin
          w_rr_idx = w_rr_idx;
        end
        if (in_valid[IW'(w_rr_idx)]) begin
          w_gnt_idx = IW'(w_rr_idx);
          w_gnt_vld = 1'b1;
        end
      end
    end
  end

  // Granted channel payload and one-hot ready.
  always_comb begin
    w_gnt_data = {WIDTH{1'b0}};
    w_gnt_last = 1'b0;
    w_in_ready = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (w_gnt_idx == IW'(i)) begin
        w_gnt_data    = in_data[i*WIDTH +: WIDTH];
        w_gnt_last    = in_last[i];
        w_in_ready[i] = w_accept;
      end else begin
        w_in_ready[i] = 1'b0;
      end
    end
  end

  // Output register, lock and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= {WIDTH{1'b0}};
      r_out_last  <= 1'b0;
      r_out_sel   <= {SELW{1'b0}};
      r_ptr       <= {IW{1'b0}};
      r_lock      <= 1'b0;
      r_locked_ch <= {IW{1'b0}};
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_gnt_data;
      r_out_last  <= w_gnt_last;
      r_out_sel   <= SELW'(w_gnt_idx);
      if (w_gnt_last) begin
        r_lock <= 1'b0;
        if (MODE == 0) begin
          r_ptr <= w_next_ptr;
        end
      end else begin
        r_lock      <= 1'b1;
        r_locked_ch <= w_gnt_idx;
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: one round-robin and one fixed-priority instance
// share the same stimulus.
module tb_arb_mux;

  logic        clk;
  logic        rst;
  logic [3:0]  v;
  logic [3:0]  l;
  logic        ordy;
  logic [31:0] din [4];
  logic [127:0] in_data;

  logic [3:0]  rdy0, rdy1;
  logic        ov0, ov1, ol0, ol1;
  logic [31:0] od0, od1;
  logic [1:0]  os0, os1;

  int n_checks;
  int n_errors;

  assign in_data = {din[3], din[2], din[1], din[0]};

  arb_mux #(.WIDTH(32), .N(4), .SELW(2), .MODE(0)) dut0 (
    .clk(clk), .reset(rst), .in_valid(v), .in_data(in_data), .in_last(l),
    .in_ready(rdy0), .out_valid(ov0), .out_data(od0), .out_last(ol0),
    .out_sel(os0), .out_ready(ordy)
  );

  arb_mux #(.WIDTH(32), .N(4), .SELW(2), .MODE(1)) dut1 (
    .clk(clk), .reset(rst), .in_valid(v), .in_data(in_data), .in_last(l),
    .in_ready(rdy1), .out_valid(ov1), .out_data(od1), .out_last(ol1),
    .out_sel(os1), .out_ready(ordy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst  = 1'b1;
    v    = 4'hF;
    l    = 4'hF;
    ordy = 1'b1;
    for (int i = 0; i < 4; i++) din[i] = 32'h10 + 32'(i);

    // Reset held two cycles with every channel valid
    tick();
    chk("rst_rdy_c1", 32'(rdy0), 32'h0);
    tick();
    chk("rst_rdy", 32'(rdy0), 32'h0);
    chk("rst_ov", 32'(ov0), 32'h0);
    chk("rst_sel", 32'(os0), 32'h0);
    chk("rst_data", od0, 32'h0);
    chk("rst_ov1", 32'(ov1), 32'h0);

    // Round-robin over single-beat packets
    rst = 1'b0;
    #1;
    chk("rr_rdy_first", 32'(rdy0), 32'h1);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr_sel", 32'(os0), 32'(k % 4));
      chk("rr_data", od0, 32'h10 + 32'(k % 4));
      chk("rr_ov", 32'(ov0), 32'h1);
      chk("fp_sel0", 32'(os1), 32'h0);
    end

    // Fixed priority: ch1 always beats ch3
    v = 4'b1010;
    #1;
    chk("fp_rdy", 32'(rdy1), 32'h2);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("fp_sel1", 32'(os1), 32'h1);
      chk("fp_rdy_hold", 32'(rdy1), 32'h2);
    end
    v = 4'b1000;
    #1;
    chk("fp_rdy3", 32'(rdy1), 32'h8);
    tick();
    chk("fp_sel3", 32'(os1), 32'h3);

    // Packet lock: move ptr to 2 with a ch1 beat, then ch2 packet against ch0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    v = 4'b0010; din[1] = 32'h55; l = 4'b0010;
    #1;
    chk("lk_rdy1", 32'(rdy0), 32'h2);
    tick();
    chk("lk_pre_sel", 32'(os0), 32'h1);
    v = 4'b0101; din[0] = 32'hC0; din[2] = 32'hA0; l = 4'b0001;
    #1;
    chk("lk_rdy_a0", 32'(rdy0), 32'h4);
    tick();
    chk("lk_a0", od0, 32'hA0);
    chk("lk_a0_sel", 32'(os0), 32'h2);
    v = 4'b0001;
    #1;
    chk("lk_gap_rdy", 32'(rdy0), 32'h0);
    tick();
    chk("lk_gap_ov", 32'(ov0), 32'h0);
    chk("lk_gap_rdy2", 32'(rdy0), 32'h0);
    tick();
    chk("lk_gap_ov2", 32'(ov0), 32'h0);
    v = 4'b0101; din[2] = 32'hA1; l = 4'b0001;
    #1;
    chk("lk_rdy_a1", 32'(rdy0), 32'h4);
    tick();
    chk("lk_a1", od0, 32'hA1);
    din[2] = 32'hA2; l = 4'b0101;
    tick();
    chk("lk_a2", od0, 32'hA2);
    chk("lk_a2_last", 32'(ol0), 32'h1);
    // ptr is now 3: ch3 beats ch0
    v = 4'b1001; din[3] = 32'hD3; l = 4'b1111;
    #1;
    chk("lk_ptr3_rdy", 32'(rdy0), 32'h8);
    tick();
    chk("lk_d3", od0, 32'hD3);
    chk("lk_d3_sel", 32'(os0), 32'h3);
    chk("lk_ptr0_rdy", 32'(rdy0), 32'h1);
    tick();
    chk("lk_c0", od0, 32'hC0);
    chk("lk_c0_sel", 32'(os0), 32'h0);

    // Back-pressure with 0x1234 from ch1 held
    v = 4'b0010; din[1] = 32'h1234;
    tick();
    chk("bp_load", od0, 32'h1234);
    chk("bp_sel", 32'(os0), 32'h1);
    ordy = 1'b0;
    v = 4'b0101; din[0] = 32'h77; din[2] = 32'h88;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_rdy", 32'(rdy0), 32'h0);
      tick();
      chk("bp_data", od0, 32'h1234);
      chk("bp_sel_hold", 32'(os0), 32'h1);
      chk("bp_ov", 32'(ov0), 32'h1);
    end
    ordy = 1'b1;
    #1;
    chk("bp_release_rdy", 32'(rdy0), 32'h4);
    tick();
    chk("bp_new_data", od0, 32'h88);
    chk("bp_new_sel", 32'(os0), 32'h2);
    chk("bp_new_ov", 32'(ov0), 32'h1);

    // Reset in the middle of a locked ch1 packet
    v = 4'b0010; din[1] = 32'hB0; l = 4'b0000;
    #1;
    chk("mr_rdy1", 32'(rdy0), 32'h2);
    tick();
    chk("mr_b0", od0, 32'hB0);
    v = 4'b0001; din[0] = 32'hE0; l = 4'b1111;
    #1;
    chk("mr_locked_rdy", 32'(rdy0), 32'h0);
    rst = 1'b1;
    #1;
    chk("mr_rst_rdy", 32'(rdy0), 32'h0);
    tick();
    chk("mr_rst_ov", 32'(ov0), 32'h0);
    rst = 1'b0;
    #1;
    chk("mr_post_rdy", 32'(rdy0), 32'h1);
    tick();
    chk("mr_e0", od0, 32'hE0);
    chk("mr_e0_sel", 32'(os0), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
